// File: rtl/lsu_pkg.sv
// Opcode constants, FSM state type and opcode classification helpers for the load/store unit.
package lsu_pkg;

    localparam logic [5:0] OP_LWZ  = 6'd32;
    localparam logic [5:0] OP_LWZU = 6'd33;
    localparam logic [5:0] OP_LBZ  = 6'd34;
    localparam logic [5:0] OP_LBZU = 6'd35;
    localparam logic [5:0] OP_STW  = 6'd36;
    localparam logic [5:0] OP_STWU = 6'd37;
    localparam logic [5:0] OP_STB  = 6'd38;
    localparam logic [5:0] OP_STBU = 6'd39;
    localparam logic [5:0] OP_LHZ  = 6'd40;
    localparam logic [5:0] OP_LHZU = 6'd41;
    localparam logic [5:0] OP_LHA  = 6'd42;
    localparam logic [5:0] OP_STH  = 6'd44;
    localparam logic [5:0] OP_STHU = 6'd45;
    localparam logic [5:0] OP_LD   = 6'd58;
    localparam logic [5:0] OP_STD  = 6'd62;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_t;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LWZ, OP_LWZU, OP_LBZ, OP_LBZU, OP_LHZ, OP_LHZU, OP_LHA, OP_LD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_STW, OP_STWU, OP_STB, OP_STBU, OP_STH, OP_STHU, OP_STD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_update(input logic [5:0] op);
        case (op)
            OP_LWZU, OP_LBZU, OP_LHZU, OP_STWU, OP_STBU, OP_STHU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_ds_form(input logic [5:0] op);
        return (op == OP_LD) || (op == OP_STD);
    endfunction

    function automatic logic [5:0] normalize_op(input logic [5:0] op);
        case (op)
            OP_LWZU:        return OP_LWZ;
            OP_LBZU:        return OP_LBZ;
            OP_LHZU, OP_LHA: return OP_LHZ;
            OP_STWU:        return OP_STW;
            OP_STBU:        return OP_STB;
            OP_STHU:        return OP_STH;
            OP_LD, OP_STD:  return 6'd0;
            default:        return op;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ea_calc.sv
// Combinational effective address and illegal-form detection; zero latency, no flow control.
module lsu_ea_calc
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [5:0]      opcode,
    input  logic [4:0]      ra_idx,
    input  logic [4:0]      rt_idx,
    input  logic [XLEN-1:0] base,
    input  logic [15:0]     disp,
    output logic [XLEN-1:0] ea,
    output logic            invalid
);

    logic [15:0]     disp_eff;
    logic [XLEN-1:0] base_eff;
    logic            upd;

    always_comb begin
        upd      = is_update(opcode);
        disp_eff = is_ds_form(opcode) ? {disp[15:2], 2'b00} : disp;
        // RA=0 reads as literal zero except for update forms, which are rejected below anyway
        base_eff = (ra_idx == 5'd0 && !upd) ? '0 : base;
        ea       = base_eff + {{(XLEN-16){disp_eff[15]}}, disp_eff};
        invalid  = !(is_load(opcode) || is_store(opcode))
                   || (upd && ra_idx == 5'd0)
                   || (upd && is_load(opcode) && ra_idx == rt_idx);
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer; one request in flight, strobe 1 cycle after accept, load response MEM_LAT+1 cycles after strobe.
// Ready only when idle; the response is held stable until resp_ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [5:0]      req_opcode,
    input  logic [4:0]      req_ra_idx,
    input  logic [4:0]      req_rt_idx,
    input  logic [XLEN-1:0] req_base,
    input  logic [15:0]     req_disp,
    input  logic [XLEN-1:0] req_wdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [5:0]      mem_opcode,
    output logic            mem_re,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_rt_we,
    output logic [4:0]      resp_rt_idx,
    output logic [XLEN-1:0] resp_rt_data,
    output logic            resp_ra_we,
    output logic [4:0]      resp_ra_idx,
    output logic [XLEN-1:0] resp_ra_data,
    output logic            resp_err
);

    lsu_state_t      state, state_nxt;
    logic [2:0]      cnt;
    logic [5:0]      op_q;
    logic [4:0]      ra_q, rt_q;
    logic [XLEN-1:0] ea_q, wdata_q, rdata_q;
    logic            inv_q;
    logic [XLEN-1:0] ea_calc;
    logic            inv_calc;
    logic            accept;

    lsu_ea_calc #(.XLEN(XLEN)) u_ea_calc (
        .opcode  (req_opcode),
        .ra_idx  (req_ra_idx),
        .rt_idx  (req_rt_idx),
        .base    (req_base),
        .disp    (req_disp),
        .ea      (ea_calc),
        .invalid (inv_calc)
    );

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = inv_calc ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = is_load(op_q) ? ST_WAIT : ST_RESP;
            ST_WAIT:  if (cnt == 3'd0) state_nxt = ST_RESP;
            ST_RESP:  if (resp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rt_we = 1'b0;
        resp_ra_we = 1'b0;
        if (state == ST_ISSUE) begin
            mem_re = is_load(op_q);
            mem_we = !is_load(op_q);
        end
        if (state == ST_RESP) begin
            resp_valid = 1'b1;
            resp_err   = inv_q;
            resp_rt_we = !inv_q && is_load(op_q);
            resp_ra_we = !inv_q && is_update(op_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= '0;
            ra_q    <= '0;
            rt_q    <= '0;
            ea_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            inv_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                op_q    <= req_opcode;
                ra_q    <= req_ra_idx;
                rt_q    <= req_rt_idx;
                ea_q    <= ea_calc;
                wdata_q <= req_wdata;
                inv_q   <= inv_calc;
            end
            if (state == ST_ISSUE)     cnt <= 3'(MEM_LAT - 1);
            else if (state == ST_WAIT) cnt <= cnt - 3'd1;
            if (state == ST_WAIT && cnt == 3'd0)
                rdata_q <= (op_q == OP_LHA) ? {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]}
                                            : mem_rdata;
        end
    end

    assign mem_addr     = ea_q;
    assign mem_wdata    = wdata_q;
    assign mem_opcode   = normalize_op(op_q);
    assign resp_rt_idx  = rt_q;
    assign resp_ra_idx  = ra_q;
    assign resp_ra_data = ea_q;
    assign resp_rt_data = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

    localparam int XLEN = 64;
    localparam int LAT  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready;
    logic [5:0]      req_opcode;
    logic [4:0]      req_ra_idx, req_rt_idx;
    logic [XLEN-1:0] req_base, req_wdata;
    logic [15:0]     req_disp;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [5:0]      mem_opcode;
    logic            mem_re, mem_we;
    logic            resp_valid, resp_ready;
    logic            resp_rt_we, resp_ra_we, resp_err;
    logic [4:0]      resp_rt_idx, resp_ra_idx;
    logic [XLEN-1:0] resp_rt_data, resp_ra_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            err;
        logic            load;
        logic            upd;
        logic [63:0]     ea;
        logic [5:0]      mop;
        logic [63:0]     rt_data;
    } exp_t;

    load_store_unit #(.XLEN(XLEN), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_ra_idx(req_ra_idx), .req_rt_idx(req_rt_idx),
        .req_base(req_base), .req_disp(req_disp), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_opcode(mem_opcode),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rt_we(resp_rt_we), .resp_rt_idx(resp_rt_idx), .resp_rt_data(resp_rt_data),
        .resp_ra_we(resp_ra_we), .resp_ra_idx(resp_ra_idx), .resp_ra_data(resp_ra_data),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rt,
                                   input logic [63:0] base, input logic [15:0] disp,
                                   input logic [63:0] rdata);
        exp_t e;
        logic legal;
        logic [15:0] d;
        logic [63:0] b;
        e.load = op inside {32, 33, 34, 35, 40, 41, 42, 58};
        legal  = e.load || (op inside {36, 37, 38, 39, 44, 45, 62});
        e.upd  = op inside {33, 35, 41, 37, 39, 45};
        e.err  = !legal || (e.upd && ra == 0) || (e.upd && e.load && ra == rt);
        d = disp;
        if (op == 58 || op == 62) d[1:0] = 2'b00;
        b = (ra == 0 && !e.upd) ? 64'd0 : base;
        e.ea = b + 64'($signed(d));
        if (e.upd)                       e.mop = op - 6'd1;
        else if (op == 42)               e.mop = 6'd40;
        else if (op == 58 || op == 62)   e.mop = 6'd0;
        else                             e.mop = op;
        e.rt_data = (op == 42) ? 64'($signed(rdata[15:0])) : rdata;
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_resp(input exp_t e, input logic [4:0] ra, input logic [4:0] rt);
        chk("resp_valid", resp_valid, 1);
        chk("resp_err", resp_err, e.err);
        chk("resp_rt_we", resp_rt_we, !e.err && e.load);
        chk("resp_ra_we", resp_ra_we, !e.err && e.upd);
        chk("req_ready_resp", req_ready, 0);
        if (!e.err && e.load) begin
            chk("resp_rt_idx", resp_rt_idx, rt);
            chk("resp_rt_data", resp_rt_data, e.rt_data);
        end
        if (!e.err && e.upd) begin
            chk("resp_ra_idx", resp_ra_idx, ra);
            chk("resp_ra_data", resp_ra_data, e.ea);
        end
    endtask

    task automatic run_txn(input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rt,
                           input logic [63:0] base, input logic [15:0] disp,
                           input logic [63:0] wdata, input logic [63:0] rdata, input int stall);
        exp_t e;
        e = model(op, ra, rt, base, disp, rdata);
        @(negedge clk);
        req_opcode = op; req_ra_idx = ra; req_rt_idx = rt;
        req_base = base; req_disp = disp; req_wdata = wdata; req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid  = 1'b0;
        req_opcode = 6'($urandom); req_base = rnd64(); req_disp = 16'($urandom); req_wdata = rnd64();
        chk("req_ready_busy", req_ready, 0);
        if (e.err) begin
            chk("no_re_err", mem_re, 0);
            chk("no_we_err", mem_we, 0);
        end else begin
            chk("mem_re", mem_re, e.load);
            chk("mem_we", mem_we, !e.load);
            chk("mem_addr", mem_addr, e.ea);
            chk("mem_opcode", mem_opcode, e.mop);
            if (!e.load) chk("mem_wdata", mem_wdata, wdata);
            if (e.load) begin
                for (int k = 1; k <= LAT; k++) begin
                    @(negedge clk);
                    mem_rdata = (k == LAT) ? rdata : rnd64();
                    chk("strobe_single", mem_re | mem_we, 0);
                    chk("no_early_resp", resp_valid, 0);
                end
            end
            @(negedge clk);
            mem_rdata = rnd64();
        end
        for (int s = 0; s <= stall; s++) begin
            check_resp(e, ra, rt);
            if (s == stall) resp_ready = 1'b1;
            if (s != stall) @(negedge clk);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_done", resp_valid, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    initial begin
        logic [5:0] ops [18];
        ops = '{32, 33, 34, 35, 40, 41, 42, 58, 36, 37, 38, 39, 44, 45, 62, 50, 0, 63};
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_opcode = '0; req_ra_idx = '0; req_rt_idx = '0;
        req_base = '0; req_disp = '0; req_wdata = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_opcode", mem_opcode, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_rt_data", resp_rt_data, 0);
        rst_n = 1'b1;

        run_txn(6'd35, 5'd3, 5'd4, 64'h100, 16'hFFF8, 64'h0, 64'hAB, 0);
        run_txn(6'd42, 5'd0, 5'd7, 64'hDEAD, 16'h0010, 64'h0, 64'h8001, 0);
        run_txn(6'd62, 5'd1, 5'd2, 64'h40, 16'h0007, 64'h1234, 64'h0, 0);
        run_txn(6'd58, 5'd9, 5'd9, 64'h1000, 16'hFFFF, 64'h0, 64'hFEDC_BA98_7654_3210, 1);
        run_txn(6'd50, 5'd1, 5'd2, 64'h10, 16'h4, 64'h0, 64'h0, 0);
        run_txn(6'd37, 5'd0, 5'd2, 64'h10, 16'h4, 64'h55, 64'h0, 0);
        run_txn(6'd33, 5'd5, 5'd5, 64'h10, 16'h4, 64'h0, 64'h0, 0);
        run_txn(6'd37, 5'd5, 5'd5, 64'h10, 16'h4, 64'h77, 64'h0, 0);
        run_txn(6'd41, 5'd6, 5'd8, 64'hFFFF_FFFF_FFFF_FFF0, 16'h0020, 64'h0, 64'h1_8001, 4);

        // reset while waiting on memory: response must be dropped
        @(negedge clk);
        req_opcode = 6'd32; req_ra_idx = 5'd2; req_rt_idx = 5'd3; req_base = 64'h200;
        req_disp = 16'h8; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstw_strobe", mem_re, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstw_req_ready", req_ready, 1);
        chk("rstw_resp_valid", resp_valid, 0);
        chk("rstw_mem_re", mem_re, 0);
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            chk("rstw_quiet", resp_valid | mem_re | mem_we, 0);
        end

        for (int n = 0; n < 60; n++) begin
            run_txn(ops[$urandom_range(17, 0)], 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                    rnd64(), 16'($urandom), rnd64(), rnd64(), $urandom_range(2, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage sequencer between execute and the 64-bit data memory. Accepts one load/store request per transaction over a valid/ready handshake. Computes the effective address, drives the data memory's access signals with a normalized opcode for one cycle, and waits a fixed memory latency. Returns a writeback packet to the register-file stage, with sign extension, update-form base writeback and an illegal-form error.

## Interface
- `XLEN`, 64: data/address width.
- `MEM_LAT`, 1: cycles from memory strobe to valid `mem_rdata`; legal range 1..7.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_opcode` in 6: primary opcode.
- `req_ra_idx`, `req_rt_idx` in 5: base and target/source register indices.
- `req_base` in XLEN: RA contents.
- `req_disp` in 16: D/DS field.
- `req_wdata` in XLEN: RS contents for stores.
- `mem_addr` out XLEN: effective address to memory.
- `mem_wdata` out XLEN: store data.
- `mem_opcode` out 6: normalized opcode, 32/34/40/36/38/44, or 0 for doubleword.
- `mem_re`, `mem_we` out 1: one-cycle access strobes.
- `mem_rdata` in XLEN: zero-extended read data.
- `resp_valid` out 1, `resp_ready` in 1: response handshake.
- `resp_rt_we` out 1, `resp_rt_idx` out 5, `resp_rt_data` out XLEN: load result.
- `resp_ra_we` out 1, `resp_ra_idx` out 5, `resp_ra_data` out XLEN: update-form base writeback (EA).
- `resp_err` out 1: illegal opcode or invalid form.

## Operation
- Legal opcodes:
  - Loads: lwz 32, lwzu 33, lbz 34, lbzu 35, lhz 40, lhzu 41, lha 42, ld 58.
  - Stores: stw 36, stwu 37, stb 38, stbu 39, sth 44, sthu 45, std 62.
- Normalization to `mem_opcode`: update forms map to the base opcode (33→32, 35→34, 41→40, 37→36, 39→38, 45→44); lha→40; ld and std→0.
- Effective address:
  - EA = (ra_idx==0 && !update ? 0 : base) + sext(disp), modulo 2^XLEN.
  - For opcodes 58 and 62, disp[1:0] is forced to 0 before extension.
- Load result:
  - lha: sext of `mem_rdata[15:0]`.
  - All other loads: `mem_rdata` passed unchanged.
- Invalid forms, which raise `resp_err` with no memory strobe and all `_we` = 0:
  - Any opcode outside the legal list.
  - Update form with ra_idx==0.
  - Load-update with ra_idx==rt_idx.
- Update forms set `resp_ra_we`=1, `resp_ra_idx`=ra_idx and `resp_ra_data`=EA.
- Stores never set `resp_rt_we`.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE→ISSUE on accept (legal request); IDLE→RESP on accept (invalid request).
  - ISSUE: one cycle with `mem_re` or `mem_we`=1. Store→RESP; load→WAIT with counter = MEM_LAT−1.
  - WAIT: counter decrements each cycle. At 0, capture `mem_rdata` and go to RESP.
  - RESP: `resp_valid`=1, held stable until `resp_ready`, then go to IDLE.

## Timing
- `req_ready`=1 only in IDLE. Accept occurs on a cycle where `req_valid` && `req_ready`; request fields are registered at that edge.
- Strobe asserts exactly one cycle, in the cycle after accept. `mem_addr`, `mem_wdata` and `mem_opcode` are stable during that cycle.
- Load: `mem_rdata` is sampled MEM_LAT cycles after the strobe cycle; `resp_valid` rises the following cycle.
- Store: `resp_valid` in the cycle after the strobe.
- Invalid request: `resp_valid` in the cycle after accept.
- Back-to-back: new accept no earlier than the cycle after the RESP handshake. No overlap and no combinational ready→valid path.
- Reset value of every output is 0, except `req_ready`=1 from the first cycle after reset.
- Reset in any state → IDLE at that edge. A strobe in flight deasserts, the captured data is discarded, and no response is produced.

## Structure
- `lsu_pkg`:
  - Opcode localparams.
  - State enum.
  - Functions `is_load`, `is_update`, `is_ds_form` and `normalize_op`.
- Sub-module `lsu_ea_calc`: combinational EA and invalid-form check, instantiated once.

## Test plan
- lbzu ra=3 base=0x100 disp=0xFFF8 rt=4, mem_rdata=0xAB, MEM_LAT=1 → strobe at addr 0xF8 with opcode 34. Response: rt_data=0xAB, ra_we=1, ra_data=0xF8.
- lha ra=0 disp=0x0010, mem_rdata=0x8001 → EA=0x10, opcode 40, rt_data=0xFFFF_FFFF_FFFF_8001.
- std ra=1 base=0x40 disp=0x0007, wdata=0x1234 → addr 0x44, opcode 0, `mem_we` for 1 cycle. Response: rt_we=0, ra_we=0.
- Invalid requests: opcode 50, stwu with ra=0, and lwzu with ra=rt=5 → no strobe; resp_err=1 one cycle after accept.
- Backpressure and latency: MEM_LAT=3 with resp_ready low for 4 cycles → response fields stable and req_ready=0 throughout.
- Reset in WAIT → next cycle idle, req_ready=1, no resp_valid.
